// File: rtl/ocp_slave_fsm_pkg.sv
// Shared OCP encodings and slave FSM state type for the bring-up OCP target.
package ocp_slave_fsm_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE = 3'd0,
    CMD_WR   = 3'd1,
    CMD_RD   = 3'd2,
    CMD_RDEX = 3'd3,
    CMD_RDL  = 3'd4,
    CMD_WRNP = 3'd5,
    CMD_WRC  = 3'd6,
    CMD_BCST = 3'd7
  } ocp_cmd_e;

  typedef enum logic [1:0] {
    RESP_NULL = 2'd0,
    RESP_DVA  = 2'd1,
    RESP_FAIL = 2'd2,
    RESP_ERR  = 2'd3
  } ocp_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCEPT = 2'd2,
    ST_RESP   = 2'd3
  } slv_state_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Commands this target recognises on the wire but does not implement.
  function automatic logic cmd_is_unsupported(input logic [2:0] cmd);
    return (cmd == CMD_RDEX) || (cmd == CMD_RDL) || (cmd == CMD_WRC) || (cmd == CMD_BCST);
  endfunction

endpackage

// File: rtl/ocp_slave_mem.sv
// Flop register array: one synchronous write port gated by the clock enable,
// one combinational read port; async reset clears every entry.
module ocp_slave_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else if (en_i && we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ocp_slave_fsm.sv
// OCP slave endpoint: captures one command, inserts WAIT_STATES before SCmdAccept,
// executes against a local register array and returns DVA/ERR (posted WR gets none).
module ocp_slave_fsm
  import ocp_slave_fsm_pkg::*;
#(
  parameter int                     MADDR_WIDTH = 64,
  parameter int                     MDATA_WIDTH = 8,
  parameter int                     SDATA_WIDTH = 8,
  parameter int                     MEM_AW      = 4,
  parameter logic [MADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                     WAIT_STATES = 1
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   EnableClk,
  input  logic [2:0]             MCmd,
  input  logic [MADDR_WIDTH-1:0] MAddr,
  input  logic [MDATA_WIDTH-1:0] MData,
  output logic                   SCmdAccept,
  output logic [1:0]             SResp,
  output logic [SDATA_WIDTH-1:0] SData,
  output logic [7:0]             err_count
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  slv_state_e             state_q;
  logic [3:0]             cnt_q;
  logic [2:0]             cmd_q;
  logic [MADDR_WIDTH-1:0] addr_q;
  logic [MDATA_WIDTH-1:0] data_q;
  logic                   acc_q;
  logic [1:0]             resp_q;
  logic [SDATA_WIDTH-1:0] sdata_q;
  logic [7:0]             err_cnt_q;

  logic                   in_range;
  logic                   is_err;
  logic                   mem_we;
  logic [MDATA_WIDTH-1:0] mem_rdata;

  assign in_range = (addr_q[MADDR_WIDTH-1:MEM_AW] == BASE_ADDR[MADDR_WIDTH-1:MEM_AW]);
  assign is_err   = !in_range || cmd_is_unsupported(cmd_q);
  assign mem_we   = (state_q == ST_ACCEPT) && !is_err &&
                    ((cmd_q == CMD_WR) || (cmd_q == CMD_WRNP));

  ocp_slave_mem #(
    .AW (MEM_AW),
    .DW (MDATA_WIDTH)
  ) u_mem (
    .clk_i   (Clk),
    .rst_i   (reset),
    .en_i    (EnableClk),
    .we_i    (mem_we),
    .waddr_i (addr_q[MEM_AW-1:0]),
    .wdata_i (data_q),
    .raddr_i (addr_q[MEM_AW-1:0]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_q     <= CMD_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      acc_q     <= 1'b0;
      resp_q    <= RESP_NULL;
      sdata_q   <= '0;
      err_cnt_q <= '0;
    end else if (EnableClk) begin
      case (state_q)
        ST_IDLE: begin
          if (MCmd != CMD_IDLE) begin
            cmd_q  <= MCmd;
            addr_q <= MAddr;
            data_q <= MData;
            cnt_q  <= WS;
            if (WS == 4'd0) begin
              state_q <= ST_ACCEPT;
              acc_q   <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // cnt_q counts the remaining wait cycles including this one.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_ACCEPT;
            acc_q   <= 1'b1;
          end
        end
        ST_ACCEPT: begin
          acc_q <= 1'b0;
          if (is_err && (err_cnt_q != ERR_CNT_MAX)) err_cnt_q <= err_cnt_q + 8'd1;
          if (cmd_q == CMD_WR) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
            if (is_err) begin
              resp_q  <= RESP_ERR;
              sdata_q <= '0;
            end else if (cmd_q == CMD_RD) begin
              resp_q  <= RESP_DVA;
              sdata_q <= mem_rdata;
            end else begin
              resp_q  <= RESP_DVA;
              sdata_q <= '0;
            end
          end
        end
        ST_RESP: begin
          // No MRespAccept: the response is visible for exactly one cycle.
          state_q <= ST_IDLE;
          resp_q  <= RESP_NULL;
          sdata_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign SCmdAccept = acc_q;
  assign SResp      = resp_q;
  assign SData      = sdata_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// Randomized bench for ocp_slave_fsm against a transaction-level model of the target.
module tb_ocp_slave_fsm;

  localparam int W = 1;

  logic        Clk = 1'b0;
  logic        reset;
  logic        EnableClk;
  logic [2:0]  MCmd;
  logic [63:0] MAddr;
  logic [7:0]  MData;
  logic        SCmdAccept;
  logic [1:0]  SResp;
  logic [7:0]  SData;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mdl_mem [16];
  int         mdl_err;

  ocp_slave_fsm #(
    .MADDR_WIDTH (64),
    .MDATA_WIDTH (8),
    .SDATA_WIDTH (8),
    .MEM_AW      (4),
    .BASE_ADDR   (64'h0),
    .WAIT_STATES (W)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .EnableClk  (EnableClk),
    .MCmd       (MCmd),
    .MAddr      (MAddr),
    .MData      (MData),
    .SCmdAccept (SCmdAccept),
    .SResp      (SResp),
    .SData      (SData),
    .err_count  (err_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    mdl_err = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_acc"},  64'(SCmdAccept), 64'd0);
    chk({tag, "_resp"}, 64'(SResp),      64'd0);
    chk({tag, "_data"}, 64'(SData),      64'd0);
    chk({tag, "_err"},  64'(err_count),  64'd0);
  endtask

  // Assert reset away from the clock edge, check outputs at once, release on a negedge.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs(tag);
    @(negedge Clk);
    reset = 1'b0;
    mdl_clear();
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge with the DUT idle.
  // k = number of enabled-off edges inserted right after the command is sampled.
  task automatic run_cmd(input logic [2:0] cmd, input logic [63:0] addr,
                         input logic [7:0] data, input int k);
    logic       err;
    logic       posted;
    logic [1:0] er;
    logic [7:0] ed;
    logic [3:0] idx;
    int         acc_cyc;
    int         last;
    idx    = addr[3:0];
    err    = (addr[63:4] != 60'h0) || (cmd inside {3'd3, 3'd4, 3'd6, 3'd7});
    posted = (cmd == 3'd1);
    if (posted)           begin er = 2'd0; ed = 8'h00; end
    else if (err)         begin er = 2'd3; ed = 8'h00; end
    else if (cmd == 3'd2) begin er = 2'd1; ed = mdl_mem[idx]; end
    else                  begin er = 2'd1; ed = 8'h00; end
    if (!err && (cmd == 3'd1 || cmd == 3'd5)) mdl_mem[idx] = data;
    if (err && mdl_err < 255) mdl_err++;
    acc_cyc = 1 + W + k;
    last    = posted ? acc_cyc + 1 : acc_cyc + 2;

    MCmd  = cmd;
    MAddr = addr;
    MData = data;
    @(posedge Clk);
    #1;
    // Junk on the inputs must be ignored until the FSM returns to IDLE.
    MCmd      = 3'($urandom_range(1, 7));
    MAddr     = {$urandom, $urandom};
    MData     = 8'($urandom);
    EnableClk = (k == 0);
    for (int c = 1; c <= last; c++) begin
      @(negedge Clk);
      chk("accept", 64'(SCmdAccept), 64'(c == acc_cyc));
      if (c <= acc_cyc) chk("resp_pre", 64'(SResp), 64'd0);
      if (c == acc_cyc + 1) begin
        chk("resp",   64'(SResp),     64'(er));
        chk("sdata",  64'(SData),     64'(ed));
        chk("errcnt", 64'(err_count), 64'(mdl_err));
      end
      if (c == acc_cyc + 2) begin
        chk("resp_post",  64'(SResp), 64'd0);
        chk("sdata_post", 64'(SData), 64'd0);
      end
      if (c < last) begin
        @(posedge Clk);
        #1;
        EnableClk = (c >= k);
        if (c >= acc_cyc) MCmd = 3'd0;
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    EnableClk = 1'b1;
    MCmd      = 3'd0;
    MAddr     = '0;
    MData     = '0;
    mdl_clear();
    #1;
    chk_reset_outputs("por");
    @(negedge Clk);
    reset = 1'b0;

    run_cmd(3'd5, 64'h3, 8'hA5, 0);
    run_cmd(3'd2, 64'h3, 8'h00, 0);
    run_cmd(3'd1, 64'hF, 8'hFF, 0);
    run_cmd(3'd2, 64'hF, 8'h00, 0);
    run_cmd(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0);
    run_cmd(3'd3, 64'h0, 8'h77, 0);
    run_cmd(3'd2, 64'h0, 8'h00, 0);
    run_cmd(3'd1, 64'h10, 8'h11, 0);
    run_cmd(3'd2, 64'h3, 8'h00, 3);
    run_cmd(3'd5, 64'h7, 8'h3C, 2);

    for (int n = 0; n < 150; n++) begin
      logic [63:0] a;
      int          k;
      if ($urandom_range(0, 7) == 0) a = {$urandom, $urandom};
      else                           a = 64'($urandom_range(0, 15));
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_cmd(3'($urandom_range(1, 7)), a, 8'($urandom), k);
    end
    for (int i = 0; i < 16; i++) run_cmd(3'd2, 64'(i), 8'h00, 0);

    // Reset while a response is on the bus; the write that produced it is wiped too.
    MCmd  = 3'd5;
    MAddr = 64'h2;
    MData = 8'h5A;
    @(posedge Clk);
    #1;
    MCmd = 3'd0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("mid_resp", 64'(SResp), 64'd1);
    pulse_reset("rst_resp");
    run_cmd(3'd2, 64'h2, 8'h00, 0);

    // Reset while the command is still waiting for accept.
    run_cmd(3'd5, 64'h9, 8'hC3, 0);
    MCmd  = 3'd2;
    MAddr = 64'h9;
    @(posedge Clk);
    #1;
    MCmd = 3'd0;
    pulse_reset("rst_wait");
    run_cmd(3'd2, 64'h9, 8'h00, 0);

    for (int n = 0; n < 260; n++) run_cmd(3'd6, 64'h1, 8'h00, 0);
    run_cmd(3'd2, 64'h1, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
